// File: rtl/axi_burst_wr_master_pkg.sv
// rtl/axi_burst_wr_master_pkg.sv - shared FSM state type, AXI response codes and tie-off constants
package axi_burst_wr_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_DATA_WIDTH     = 1024;
  localparam int AXI_BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;

  // Tie-offs for the AXI fields this master never varies
  localparam logic [2:0] AXI_AWSIZE       = 3'($clog2(AXI_BYTES_PER_BEAT));
  localparam logic [1:0] AXI_AWBURST_INCR = 2'b01;
  localparam logic [3:0] AXI_AWID         = 4'd0;
  localparam logic [AXI_BYTES_PER_BEAT-1:0] AXI_WSTRB_ALL = '1;

endpackage

// File: rtl/axi_burst_wr_master_if.sv
// rtl/axi_burst_wr_master_if.sv - command, write-data stream and AXI AW/W/B signals of the burst write master
interface axi_burst_wr_master_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 1024,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] m00_axi_awaddr;
  logic [7:0]            m00_axi_awlen;
  logic                  m00_axi_awvalid;
  logic                  m00_axi_awready;
  logic [DATA_WIDTH-1:0] m00_axi_wdata;
  logic                  m00_axi_wlast;
  logic                  m00_axi_wvalid;
  logic                  m00_axi_wready;
  logic [1:0]            m00_axi_bresp;
  logic                  m00_axi_bvalid;
  logic                  m00_axi_bready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, s_data, s_valid,
           m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
    output cmd_ready, s_ready, done, err,
           m00_axi_awaddr, m00_axi_awlen, m00_axi_awvalid,
           m00_axi_wdata, m00_axi_wlast, m00_axi_wvalid, m00_axi_bready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, s_data, s_valid,
           m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
    input  cmd_ready, s_ready, done, err,
           m00_axi_awaddr, m00_axi_awlen, m00_axi_awvalid,
           m00_axi_wdata, m00_axi_wlast, m00_axi_wvalid, m00_axi_bready
  );
endinterface

// File: rtl/axi_wr_watchdog.sv
// rtl/axi_wr_watchdog.sv - load/count/expire counter bounding the wait for a write response
module axi_wr_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Fires on the LIMIT-th consecutive counted cycle
  assign expired = count && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/axi_burst_wr_master.sv
// rtl/axi_burst_wr_master.sv - command-driven AXI4 write-burst master, one burst outstanding
// Optional B-response watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_burst_wr_master
  import axi_burst_wr_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 1024,
  parameter int LEN_WIDTH      = 8,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   m00_axi_aclk,
  input  logic                   m00_axi_areset,
  axi_burst_wr_master_if.master  bus
);
  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;

  wr_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic [7:0]            awlen_q;
  logic [7:0]            beat_cnt_q;
  logic                  err_q;
  logic [8:0]            this_len;
  logic [LEN_WIDTH-1:0]  beats_after;
  logic                  last_beat;
  logic                  w_fire;
  logic                  timeout;

  function automatic logic [7:0] burst_awlen(input logic [LEN_WIDTH-1:0] beats);
    if (int'(beats) > MAX_BURST) return 8'(MAX_BURST - 1);
    return 8'(int'(beats) - 1);
  endfunction

  assign this_len    = {1'b0, awlen_q} + 9'd1;
  assign beats_after = beats_left_q - LEN_WIDTH'(this_len);
  assign last_beat   = (beat_cnt_q == awlen_q);
  assign w_fire      = (state == ST_W) && bus.s_valid && bus.m00_axi_wready;

`ifdef AXI_WR_TIMEOUT_EN
  axi_wr_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (m00_axi_aclk),
    .rst     (m00_axi_areset),
    .load    (state != ST_B),
    .count   ((state == ST_B) && !bus.m00_axi_bvalid),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) state <= ST_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next          = state;
    bus.cmd_ready       = 1'b0;
    bus.s_ready         = 1'b0;
    bus.done            = 1'b0;
    bus.err             = 1'b0;
    bus.m00_axi_awaddr  = addr_q;
    bus.m00_axi_awlen   = awlen_q;
    bus.m00_axi_awvalid = 1'b0;
    bus.m00_axi_wdata   = bus.s_data;
    bus.m00_axi_wlast   = 1'b0;
    bus.m00_axi_wvalid  = 1'b0;
    bus.m00_axi_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = (bus.cmd_len == '0) ? ST_DONE : ST_AW;
      end
      ST_AW: begin
        bus.m00_axi_awvalid = 1'b1;
        if (bus.m00_axi_awready) state_next = ST_W;
      end
      ST_W: begin
        bus.m00_axi_wvalid = bus.s_valid;
        bus.s_ready        = bus.m00_axi_wready;
        bus.m00_axi_wlast  = last_beat;
        if (w_fire && last_beat) state_next = ST_B;
      end
      ST_B: begin
        bus.m00_axi_bready = 1'b1;
        if (bus.m00_axi_bvalid) state_next = (beats_after == '0) ? ST_DONE : ST_AW;
        else if (timeout)       state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        bus.err    = err_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      addr_q       <= '0;
      beats_left_q <= '0;
      awlen_q      <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr_q       <= bus.cmd_addr;
            beats_left_q <= bus.cmd_len;
            err_q        <= 1'b0;
            awlen_q      <= (bus.cmd_len != '0) ? burst_awlen(bus.cmd_len) : 8'd0;
          end
        end
        ST_AW: beat_cnt_q <= '0;
        ST_W: begin
          if (w_fire) beat_cnt_q <= beat_cnt_q + 8'd1;
        end
        ST_B: begin
          if (bus.m00_axi_bvalid) begin
            if (bus.m00_axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            beats_left_q <= beats_after;
            // Address wraps silently at the top of the address space
            addr_q <= addr_q + ADDR_WIDTH'(int'(this_len) * BYTES_PER_BEAT);
            if (beats_after != '0) awlen_q <= burst_awlen(beats_after);
          end else if (timeout) begin
            err_q        <= 1'b1;
            beats_left_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_wr_master.sv
// tb/tb_axi_burst_wr_master.sv - randomized self-checking bench with a burst-splitting reference model
module tb_axi_burst_wr_master;
  import axi_burst_wr_master_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 1024;
  localparam int LW    = 8;
  localparam int MAXB  = 16;
  localparam int BPB   = DW / 8;
  localparam int TMO   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  axi_burst_wr_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  axi_burst_wr_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .m00_axi_aclk   (clk),
    .m00_axi_areset (rst),
    .bus            (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] fold(input logic [DW-1:0] d);
    logic [63:0] r = '0;
    for (int i = 0; i < DW / 64; i++) r = {r[62:0], r[63]} ^ d[i*64 +: 64];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.m00_axi_awready = 1'b0; bus.m00_axi_wready = 1'b0;
    bus.m00_axi_bvalid = 1'b0; bus.m00_axi_bresp = AXI_RESP_OKAY;
  endtask

  // One command end to end; the slave and source are modelled inline cycle by cycle
  task automatic run_cmd(input int addr, input int len, input bit gaps, input int err_burst,
                         input bit hold_b, input bit rst_mid, input int exp_lat);
    logic [DW-1:0] beats[$];
    int   exp_addr[$];
    int   exp_len[$];
    int   rem, a, l, n_aw_exp, n_w_exp;
    int   src_idx = 0, w_idx = 0, burst_w = 0, wb = 0, b_idx = 0, aw_idx = 0;
    int   cyc = 0, t_acc = 0, t_wlast = 0, t_done = 0;
    bit   accepted = 0, pending_b = 0, got_done = 0, aborted = 0, aw_hold = 0, exp_err, exp_last;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;

    rem = len; a = addr;
    while (rem > 0) begin
      l = (rem > MAXB) ? MAXB : rem;
      exp_addr.push_back(a); exp_len.push_back(l);
      a = (a + l * BPB) % (1 << AW);
      rem -= l;
    end
    for (int i = 0; i < len; i++) beats.push_back(rand_beat());
    exp_err  = hold_b || (err_burst >= 0 && err_burst < exp_len.size());
    n_aw_exp = hold_b ? 1 : exp_len.size();
    n_w_exp  = hold_b ? exp_len[0] : len;

    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      bus.cmd_valid = !accepted;
      bus.cmd_addr  = AW'(addr);
      bus.cmd_len   = LW'(len);
      bus.s_valid   = (src_idx < len) && (!gaps || $urandom_range(0, 2) != 0);
      bus.s_data    = (src_idx < len) ? beats[src_idx] : '0;
      bus.m00_axi_awready = !gaps || $urandom_range(0, 1) != 0;
      bus.m00_axi_wready  = !gaps || $urandom_range(0, 2) != 0;
      bus.m00_axi_bvalid  = pending_b && !hold_b && (!gaps || $urandom_range(0, 1) != 0);
      bus.m00_axi_bresp   = (b_idx == err_burst) ? ((b_idx % 2) ? AXI_RESP_SLVERR : AXI_RESP_DECERR)
                                                 : AXI_RESP_OKAY;
      #1;
      if (rst_mid && w_idx == 2 && bus.m00_axi_wvalid) begin
        rst = 1'b1;
        #1;
        chk("rst_awvalid", bus.m00_axi_awvalid, 0);
        chk("rst_wvalid", bus.m00_axi_wvalid, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin accepted = 1; t_acc = cyc; end
      if (aw_hold) begin
        chk("aw_stable_valid", bus.m00_axi_awvalid, 1);
        chk("aw_stable_addr", bus.m00_axi_awaddr, prev_addr);
        chk("aw_stable_len", bus.m00_axi_awlen, prev_len);
      end
      aw_hold = 0;
      chk("aw_w_exclusive", bus.m00_axi_awvalid && (bus.m00_axi_wvalid || bus.s_ready), 0);
      if (bus.m00_axi_awvalid) begin
        if (bus.m00_axi_awready) begin
          if (aw_idx < n_aw_exp) begin
            chk("awaddr", bus.m00_axi_awaddr, exp_addr[aw_idx]);
            chk("awlen", bus.m00_axi_awlen, exp_len[aw_idx] - 1);
          end else chk("aw_extra", 1, 0);
          aw_idx++;
        end else begin
          aw_hold = 1; prev_addr = bus.m00_axi_awaddr; prev_len = bus.m00_axi_awlen;
        end
      end
      if (bus.s_valid && bus.s_ready) src_idx++;
      if (bus.m00_axi_wvalid && bus.m00_axi_wready) begin
        if (w_idx < len && wb < exp_len.size()) begin
          exp_last = (burst_w == exp_len[wb] - 1);
          chk("wdata", fold(bus.m00_axi_wdata), fold(beats[w_idx]));
          chk("wlast", bus.m00_axi_wlast, exp_last);
          if (exp_last) begin pending_b = 1; t_wlast = cyc; burst_w = 0; wb++; end
          else burst_w++;
        end else chk("w_extra", 1, 0);
        w_idx++;
      end
      if (bus.m00_axi_bvalid && bus.m00_axi_bready) begin pending_b = 0; b_idx++; end
      if (bus.done) begin
        got_done = 1; t_done = cyc;
        chk("err", bus.err, exp_err);
      end
      cyc++;
    end

    if (!aborted) begin
      chk("done_seen", got_done, 1);
      chk("aw_count", aw_idx, n_aw_exp);
      chk("w_count", w_idx, n_w_exp);
      if (!hold_b) chk("b_count", b_idx, exp_len.size());
      if (exp_lat >= 0) chk("done_latency", t_done - t_acc, exp_lat);
      if (hold_b) chk("timeout_latency", t_done - t_wlast, TMO + 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("done_pulse_drop", bus.done, 0);
      chk("back_idle", bus.cmd_ready, 1);
      chk("bready_idle", bus.m00_axi_bready, 0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_s_ready", bus.s_ready, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_awaddr", bus.m00_axi_awaddr, 0);
    chk("reset_awlen", bus.m00_axi_awlen, 0);
    chk("reset_awvalid", bus.m00_axi_awvalid, 0);
    chk("reset_wvalid", bus.m00_axi_wvalid, 0);
    chk("reset_wlast", bus.m00_axi_wlast, 0);
    chk("reset_bready", bus.m00_axi_bready, 0);
    @(negedge clk);
    rst = 1'b0;

    run_cmd(0, 4, 0, -1, 0, 0, 7);
    run_cmd(0, 40, 0, -1, 0, 0, -1);
    run_cmd('h780, 2, 1, -1, 0, 0, -1);
    run_cmd(0, 40, 1, 1, 0, 0, -1);
    run_cmd('h100, 3, 0, -1, 0, 0, 6);
    run_cmd('h200, 0, 0, -1, 0, 0, 1);
    run_cmd(0, 16, 0, -1, 0, 0, 19);
    run_cmd('h380, 17, 1, 0, 0, 0, -1);
    for (int i = 0; i < 8; i++)
      run_cmd($urandom_range(0, 15) * BPB, $urandom_range(0, 50), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)) - 1, 0, 0, -1);
    run_cmd(0, 8, 0, -1, 0, 1, -1);
    run_cmd('h80, 5, 0, -1, 0, 0, 8);
`ifdef AXI_WR_TIMEOUT_EN
    run_cmd(0, 20, 0, -1, 1, 0, -1);
    run_cmd('h100, 3, 0, -1, 0, 0, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
